// File: rtl/wf_bram256x16_arb.sv
// Two-requester arbiter in front of a 256x16 simple dual-port BRAM.
// Write and read ports arbitrate independently; same-address reads defer.
module wf_bram256x16_arb #(
  parameter bit RR_EN = 1'b1,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_wen,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_ren,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata
);

  // Pointers and owner: 0 selects A, 1 selects B.
  logic wptr_q, wptr_d;
  logic rptr_q, rptr_d;
  logic rd_pend_q, rd_pend_d;
  logic owner_q, owner_d;

  logic a_wc, b_wc, a_rc, b_rc;
  logic w_a, w_b, r_a, r_b;
  logic w_any, r_any, hazard, r_ok;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] w_data;

  always_comb begin
    a_wc = a_req & a_we;
    b_wc = b_req & b_we;
    a_rc = a_req & ~a_we;
    b_rc = b_req & ~b_we;

    w_a = a_wc & (~b_wc | !RR_EN | ~wptr_q);
    w_b = b_wc & ~w_a;
    r_a = a_rc & (~b_rc | !RR_EN | ~rptr_q);
    r_b = b_rc & ~r_a;

    w_any  = w_a | w_b;
    r_any  = r_a | r_b;
    w_addr = w_a ? a_addr : (w_b ? b_addr : '0);
    w_data = w_a ? a_wdata : (w_b ? b_wdata : '0);
    r_addr = r_a ? a_addr : (r_b ? b_addr : '0);

    // A read colliding with the granted write waits a cycle.
    hazard = w_any & r_any & (w_addr == r_addr);
    r_ok   = r_any & ~hazard & ~reset;

    a_gnt = ~reset & (w_a | (r_a & ~hazard));
    b_gnt = ~reset & (w_b | (r_b & ~hazard));

    ram_wen   = w_any & ~reset;
    ram_waddr = ram_wen ? w_addr : '0;
    ram_wdata = ram_wen ? w_data : '0;
    ram_ren   = r_ok;
    ram_raddr = r_ok ? r_addr : '0;

    wptr_d = wptr_q;
    if (RR_EN && a_wc && b_wc) wptr_d = w_a;
    rptr_d = rptr_q;
    if (RR_EN && a_rc && b_rc && r_ok) rptr_d = r_a;

    rd_pend_d = r_ok;
    owner_d   = r_ok ? r_b : owner_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      owner_q   <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_pend_q <= rd_pend_d;
      owner_q   <= owner_d;
    end
  end

  // Returned data is suppressed while reset is held.
  always_comb begin
    a_rvalid = rd_pend_q & ~owner_q & ~reset;
    b_rvalid = rd_pend_q & owner_q & ~reset;
    a_rdata  = a_rvalid ? ram_rdata : '0;
    b_rdata  = b_rvalid ? ram_rdata : '0;
  end

endmodule
